// File: rtl/alu_pkg.sv
// Shared op-code encodings, FSM states and decode helpers for the ALU execute path.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Codes above SUB are unassigned.
    function automatic logic is_legal_op(input logic [3:0] op);
        return op <= OP_SUB;
    endfunction

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// One-bit-per-cycle shifter; the parent captures next_c on the cycle last_c is high.
module alu_serial_shifter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] data,
    input  logic [SHW-1:0]  amount,
    input  logic            left,
    input  logic            arith,
    output logic            last_c,
    output logic [XLEN-1:0] next_c
);

    logic [XLEN-1:0] work;
    logic [SHW-1:0]  count;
    logic            busy;
    logic            left_q;
    logic            arith_q;

    always_comb begin
        next_c = left_q ? {work[XLEN-2:0], 1'b0}
                        : {arith_q & work[XLEN-1], work[XLEN-1:1]};
        last_c = busy && (count == SHW'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work    <= '0;
            count   <= '0;
            busy    <= 1'b0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (start) begin
            work    <= data;
            count   <= amount;
            busy    <= (amount != '0);
            left_q  <= left;
            arith_q <= arith;
        end else if (busy) begin
            work  <= next_c;
            count <= count - SHW'(1);
            if (last_c) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: single-cycle logic/arith/compare, serial shifts.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32,
    localparam int unsigned SHW = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op
);

    state_t          state;
    state_t          next_state;
    logic            start_c;
    logic [XLEN-1:0] alu_c;
    logic            shift_last_c;
    logic [XLEN-1:0] shift_next_c;
    logic [SHW-1:0]  shamt;

    assign shamt = op_b[SHW-1:0];

    // Single-cycle datapath; a shift reaching here has shamt == 0.
    always_comb begin
        alu_c = '0;
        case (alu_op)
            OP_ADD:  alu_c = op_a + op_b;
            OP_SUB:  alu_c = op_a - op_b;
            OP_SLT:  alu_c = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU: alu_c = XLEN'(op_a < op_b);
            OP_XOR:  alu_c = op_a ^ op_b;
            OP_OR:   alu_c = op_a | op_b;
            OP_AND:  alu_c = op_a & op_b;
            OP_SLL, OP_SRL, OP_SRA: alu_c = op_a;
            default: alu_c = '0;
        endcase
    end

    alu_serial_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk    (clk),
        .rst    (rst),
        .start  (start_c),
        .data   (op_a),
        .amount (shamt),
        .left   (alu_op == OP_SLL),
        .arith  (alu_op == OP_SRA),
        .last_c (shift_last_c),
        .next_c (shift_next_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start_c    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    if (is_shift_op(alu_op) && (shamt != '0)) begin
                        start_c    = 1'b1;
                        next_state = SHIFT;
                    end else begin
                        next_state = DONE;
                    end
                end
            end
            SHIFT: begin
                if (shift_last_c) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Output registers; zero/illegal_op are cleared once the result is consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            result     <= '0;
            zero       <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (in_valid && (next_state == DONE)) begin
                        result     <= alu_c;
                        zero       <= (alu_c == '0);
                        illegal_op <= !is_legal_op(alu_op);
                    end
                end
                SHIFT: begin
                    if (shift_last_c) begin
                        result     <= shift_next_c;
                        zero       <= (shift_next_c == '0);
                        illegal_op <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        zero       <= 1'b0;
                        illegal_op <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: latency-counter reference model plus directed cases.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;

    int errors = 0;
    int checks = 0;

    alu_exec_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .op_a       (op_a),
        .op_b       (op_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference result straight from the operation definitions.
    function automatic logic [31:0] ref_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int unsigned k;
        k = int'(b[4:0]);
        case (op)
            4'd0: return a + b;
            4'd9: return a - b;
            4'd1: return a << k;
            4'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3: return (a < b) ? 32'd1 : 32'd0;
            4'd4: return a ^ b;
            4'd5: return a >> k;
            4'd6: return 32'($signed(a) >>> k);
            4'd7: return a | b;
            4'd8: return a & b;
            default: return 32'd0;
        endcase
    endfunction

    // Model: 0 = waiting for op, 1 = computing (edges remaining), 2 = result held.
    int          m_phase = 0;
    int          m_cnt = 0;
    logic [31:0] m_result = '0;
    logic        m_illegal = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    m_result  = ref_result(alu_op, op_a, op_b);
                    m_illegal = (alu_op > 4'd9);
                    m_cnt     = (alu_op == 4'd1 || alu_op == 4'd5 || alu_op == 4'd6) ? int'(op_b[4:0]) : 0;
                    m_phase   = (m_cnt == 0) ? 2 : 1;
                end
                1: begin
                    m_cnt--;
                    if (m_cnt == 0) m_phase = 2;
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("in_ready", 32'(in_ready), 32'(m_phase == 0));
            check("out_valid", 32'(out_valid), 32'(m_phase == 2));
            if (m_phase == 2) begin
                check("result", result, m_result);
                check("zero", 32'(zero), 32'(m_result == 32'd0));
                check("illegal_op", 32'(illegal_op), 32'(m_illegal));
            end else begin
                check("zero_idle", 32'(zero), 32'd0);
                check("illegal_idle", 32'(illegal_op), 32'd0);
            end
        end
    end

    // Called at posedge+2 with the unit idle; returns outputs seen at first out_valid.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] res, output logic z,
                          output logic ill, output int lat);
        alu_op   = op;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        alu_op   = 4'($urandom);
        op_a     = $urandom;
        op_b     = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #2;
            lat++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout: out_valid never rose for op %0d", op);
        end
        res = result;
        z   = zero;
        ill = illegal_op;
        repeat (hold) @(posedge clk);
        if (hold > 0) #2;
        out_ready = 1'b1;
        @(posedge clk); #2;
        out_ready = 1'b0;
    endtask

    logic [31:0] r;
    logic        z;
    logic        il;
    int          lat;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = '0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        #1 rst = 1'b0;

        // Reset three cycles into an SLL by 20.
        alu_op = 4'd1; op_a = 32'd1; op_b = 32'd20; in_valid = 1'b1;
        @(posedge clk); #2;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midshift_out_valid", 32'(out_valid), 32'd0);
        check("midshift_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #2 rst = 1'b0;
        run_op(4'd0, 32'd1, 32'd1, 0, r, z, il, lat);
        check("add_after_rst", r, 32'd2);

        run_op(4'd0, 32'hFFFF_FFFF, 32'd1, 0, r, z, il, lat);
        check("add_wrap", r, 32'd0);
        check("add_wrap_zero", 32'(z), 32'd1);
        check("add_wrap_lat", 32'(lat), 32'd1);
        run_op(4'd9, 32'd5, 32'd7, 1, r, z, il, lat);
        check("sub", r, 32'hFFFF_FFFE);
        check("sub_zero", 32'(z), 32'd0);
        run_op(4'd2, 32'h8000_0000, 32'd1, 0, r, z, il, lat);
        check("slt", r, 32'd1);
        run_op(4'd3, 32'h8000_0000, 32'd1, 0, r, z, il, lat);
        check("sltu", r, 32'd0);
        run_op(4'd6, 32'h8000_0000, 32'd4, 0, r, z, il, lat);
        check("sra", r, 32'hF800_0000);
        check("sra_lat", 32'(lat), 32'd5);
        run_op(4'd5, 32'h8000_0000, 32'd4, 0, r, z, il, lat);
        check("srl", r, 32'h0800_0000);
        run_op(4'd1, 32'h1234_5678, 32'd0, 0, r, z, il, lat);
        check("sll0", r, 32'h1234_5678);
        check("sll0_lat", 32'(lat), 32'd1);
        run_op(4'd1, 32'd1, 32'd31, 0, r, z, il, lat);
        check("sll31", r, 32'h8000_0000);
        check("sll31_lat", 32'(lat), 32'd32);
        run_op(4'd1, 32'd3, 32'h25, 0, r, z, il, lat);
        check("shamt_mask", r, 32'd96);
        check("shamt_mask_lat", 32'(lat), 32'd6);

        // Back-pressure: the model compare covers the held cycles.
        run_op(4'd4, 32'hF0, 32'hFF, 10, r, z, il, lat);
        check("xor_bp", r, 32'h0F);
        check("bp_in_ready_after", 32'(in_ready), 32'd1);

        run_op(4'b1100, 32'd7, 32'd9, 0, r, z, il, lat);
        check("illegal_res", r, 32'd0);
        check("illegal_zero", 32'(z), 32'd1);
        check("illegal_flag", 32'(il), 32'd1);
        check("illegal_lat", 32'(lat), 32'd1);
        run_op(4'd7, 32'h0F00, 32'h00F0, 0, r, z, il, lat);
        check("or_after_illegal", r, 32'h0FF0);
        check("illegal_cleared", 32'(il), 32'd0);

        for (int i = 0; i < 250; i++) begin
            logic [31:0] rb;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 3));
            run_op(4'($urandom_range(0, 15)), $urandom, rb, $urandom_range(0, 3), r, z, il, lat);
        end

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle execute unit that consumes the 4-bit ALU operation code produced by the ALU control decode and computes the result on two XLEN operands. Logic ops, add/sub and compares complete in one cycle. Shifts run serially, one bit per cycle, to avoid a barrel shifter. Sits between operand fetch and writeback, with valid/ready handshakes on both sides.

## Interface
- XLEN, 32, operand/result width; must be ≥ 8 and a power of two.
- SHW, $clog2(XLEN), width of the shift-amount field taken from op_b.
- clk  input  1  rising-edge clock (the only clock).
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  unit can accept an operation.
- alu_op  input  4  operation code, decoded as follows:
  - 0000 ADD, 1001 SUB, 0001 SLL, 0010 SLT, 0011 SLTU.
  - 0100 XOR, 0101 SRL, 0110 SRA, 0111 OR, 1000 AND.
  - 1010–1111 illegal.
- op_a  input  XLEN  first operand.
- op_b  input  XLEN  second operand; bits [SHW-1:0] give the shift amount.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- result  output  XLEN  computed value.
- zero  output  1  high when result == 0.
- illegal_op  output  1  high with out_valid when the accepted alu_op was illegal.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid, capture alu_op, op_a and op_b[SHW-1:0].
    - Shift op with shamt ≠ 0: go to SHIFT.
    - Any other op, or shamt = 0: compute, then go to DONE.
  - SHIFT: each cycle, shift the working register by 1 bit and decrement the counter.
    - SLL fills with 0; SRL fills with 0; SRA fills with the working register's MSB.
    - When the counter reaches 1, the final shift is applied and the FSM goes to DONE.
  - DONE: out_valid=1, outputs held stable. On out_ready, go to IDLE.
- No acceptance in the same cycle as DONE→IDLE; in_ready is registered state (state==IDLE).
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^XLEN; no carry or overflow outputs.
  - SLT is a signed compare; SLTU is unsigned. Both give a result of 0 or 1, zero-extended.
  - Only op_b[SHW-1:0] affects shifts; upper bits are ignored.
- Illegal op: result=0, zero=1, illegal_op=1, single-cycle path.
- Inputs are sampled only at acceptance; changes afterwards have no effect.
- Reset (any state, including mid-shift):
  - FSM goes to IDLE; any in-flight operation is discarded.
  - in_ready=1, out_valid=0, result=0, zero=0, illegal_op=0.
- zero and illegal_op are meaningful only while out_valid=1, and are driven low otherwise.

## Timing
- Acceptance edge: in_valid && in_ready at rising edge N.
- Single-cycle ops: out_valid=1 from cycle N+1.
- Shift by k ≥ 1: out_valid=1 from cycle N+1+k; worst case N+XLEN at k=XLEN-1.
- Result is held while out_valid && !out_ready; back-pressure is unbounded.
- After the out_ready handshake at edge M: in_ready=1 from M+1, and the next accept is at M+1 at the earliest.
- Throughput: one single-cycle op per 2 cycles with out_ready held high.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package alu_pkg holds:
  - localparams for the ten op codes plus a `is_legal_op` function;
  - the state enum (IDLE, SHIFT, DONE).
  - The ALU control decoder imports the same package, so the encodings cannot diverge.
- Sub-module alu_serial_shifter contains:
  - the working register and shift counter;
  - start/done handshake with the parent FSM;
  - direction and arithmetic-fill inputs.
- The parent holds the FSM, the single-cycle datapath, and the output registers.

## Test plan
- Reset mid-shift: assert rst 3 cycles into an SLL by 20.
  - Required: out_valid=0 and in_ready=1 immediately.
  - A fresh ADD 1+1 afterwards gives 2.
- ADD/SUB:
  - ADD 0xFFFFFFFF+1 → result 0, zero=1, out_valid at N+1.
  - SUB 5−7 → 0xFFFFFFFE, zero=0.
- Compares:
  - SLT 0x80000000 vs 1 → 1.
  - SLTU 0x80000000 vs 1 → 0.
- Shifts:
  - SRA 0x80000000 by 4 → 0xF8000000, out_valid at N+5.
  - SRL same operands → 0x08000000.
  - SLL by 0 → op_a at N+1.
  - SLL 1 by 31 → 0x80000000 at N+32.
  - op_b=0x25 shifts by 5.
- Back-pressure: hold out_ready=0 for 10 cycles after XOR 0xF0^0xFF.
  - Required: result stays 0x0F, in_ready=0 throughout.
  - Handshake, then in_ready=1 on the next cycle.
- Illegal op 1100: result 0, zero=1, illegal_op=1 at N+1; the next legal op clears illegal_op.
